fetch_prefetch_unit: RTL
========================

// Module: fetch_prefetch_unit
// PURPOSE
//  Instruction-fetch front end upstream of decode/execute. Issues word reads to instruction
//  memory over a req/ack bus with variable latency, buffers returned words with their PC in a
//  small FIFO, and presents {pc, instr} to decode over valid/ready. Branch/jump redirects flush
//  the FIFO and restart fetch at the new PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  4              prefetch entries; power of 2, >= 2
//  LVL_W       3              width of fifo_level = $clog2(FIFO_DEPTH)+1
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high
//  imem_req        out  1      read request; held until imem_ack
//  imem_addr       out  32     word-aligned fetch address; stable while imem_req=1
//  imem_ack        in   1      one-cycle pulse: imem_rdata valid this cycle
//  imem_rdata      in   32     returned instruction word
//  redirect_valid  in   1      one-cycle pulse: flush and refetch from redirect_pc
//  redirect_pc     in   32     redirect target; bits [1:0] forced to 0
//  if_valid        out  1      head entry available
//  if_instr        out  32     head instruction
//  if_pc           out  32     PC of head instruction
//  if_ready        in   1      decode consumes head when if_valid && if_ready
//  fifo_level      out  LVL_W  occupied entries, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, all outputs): imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0,
//   fifo_level=0, state=IDLE. Reset mid-transaction abandons the request; a late ack is ignored.
//  FSM: IDLE (no request), WAIT (request outstanding), DISCARD (stale request outstanding).
//   IDLE->WAIT when fifo_level_next < FIFO_DEPTH and no redirect; imem_req=1, imem_addr=fetch_pc.
//   WAIT, ack, no redirect: push {fetch_pc, rdata}; fetch_pc+=4; stay WAIT with new addr if
//    room after push/pop, else IDLE (req drops).
//   WAIT, no ack, redirect: -> DISCARD; req stays high at old addr (bus rule: no abandonment).
//   WAIT, ack and redirect same cycle: data dropped, fetch_pc=redirect_pc, -> WAIT (new addr).
//   DISCARD: on ack drop data, -> WAIT at fetch_pc. Further redirects only update fetch_pc.
//  Redirect: FIFO emptied same edge (fifo_level=0, if_valid=0 next cycle); pop in that cycle is
//   still honoured (decode owns the handshake); the pop and flush do not double-count.
//  FIFO: first-word-fall-through; push and pop in same cycle at full or empty both legal;
//   push when full never occurs (room checked before issue). Pointers wrap mod FIFO_DEPTH.
//  Latency: ack at cycle N -> if_valid at N+1. Back-to-back acks sustain 1 instr/cycle.
//  Arithmetic: fetch_pc increments mod 2^32 (0xFFFF_FFFC -> 0x0000_0000, no flag).
//  Redirect has priority over room check; if_valid never asserts for a flushed or stale word.
// STRUCTURE
//  fetch_pkg: fetch_state_t enum {IDLE, WAIT, DISCARD}, RESET_PC default, PC_STEP=32'd4.
//  Sub-module fetch_fifo (param DEPTH, WIDTH=64): sync FWFT FIFO with flush, level output.
//  Top holds FSM, fetch_pc register, room check, imem bus drive.
// TESTING
//  1 Reset, ack 1 cycle after each req, if_ready=1 -> addrs 0,4,8,..; if_pc matches, 1 instr/cycle.
//  2 if_ready=0, DEPTH=4 -> exactly 4 acks accepted, fifo_level=4, imem_req=0; ready=1 resumes at 0x10.
//  3 Redirect to 0x103 while WAIT at 0x8, ack 3 cycles later -> word dropped, next addr 0x100,
//    first if_pc=0x100.
//  4 Redirect and ack same cycle -> data dropped, next imem_addr=redirect_pc, level=0.
//  5 RESET_PC=0xFFFF_FFF8 -> addresses ...F8, ...FC, 0x0 wrap.
//  6 Async reset pulse mid-WAIT -> outputs at reset values immediately; stale ack after release
//    ignored; first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with flush; head and level are held in registers
// so that every output comes straight from a flop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [LVL_W-1:0] after_pop;
  logic [LVL_W-1:0] count_next;
  logic [WIDTH-1:0] head_next;

  // Next occupancy, pointers and head word; a push into an empty-after-pop FIFO bypasses storage.
  always_comb begin
    after_pop = level - (pop ? LVL_W'(1) : {LVL_W{1'b0}});
    if (flush) begin
      count_next  = {LVL_W{1'b0}};
      rd_ptr_next = {PTR_W{1'b0}};
      wr_ptr_next = {PTR_W{1'b0}};
      head_next   = {WIDTH{1'b0}};
    end else begin
      count_next  = after_pop + (push ? LVL_W'(1) : {LVL_W{1'b0}});
      rd_ptr_next = rd_ptr + (pop ? PTR_W'(1) : {PTR_W{1'b0}});
      wr_ptr_next = wr_ptr + (push ? PTR_W'(1) : {PTR_W{1'b0}});
      if (count_next == {LVL_W{1'b0}}) begin
        head_next = {WIDTH{1'b0}};
      end else if (push && (after_pop == {LVL_W{1'b0}})) begin
        head_next = wdata;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer, level and registered head state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      level  <= {LVL_W{1'b0}};
      rvalid <= 1'b0;
      rdata  <= {WIDTH{1'b0}};
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      level  <= count_next;
      rvalid <= (count_next != {LVL_W{1'b0}});
      rdata  <= head_next;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues imem reads, buffers {pc, instr} in a prefetch
// FIFO and handles redirects, including requests that must be drained after a flush.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  input  logic             if_ready,
  output logic [LVL_W-1:0] fifo_level
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_next;
  logic [31:0]  addr_next;
  logic [31:0]  target;
  logic [31:0]  pc_inc;
  logic         req_next;
  logic         push;
  logic         pop;
  logic         has_room;
  logic [LVL_W-1:0] level_next;
  logic [63:0]  head;

  // Next-state and bus drive; redirect always wins over the room check.
  always_comb begin
    target     = align_pc(redirect_pc);
    pc_inc     = fetch_pc + PC_STEP;
    pop        = if_valid && if_ready;
    push       = (state == WAIT) && imem_ack && !redirect_valid;
    if (redirect_valid) begin
      level_next = {LVL_W{1'b0}};
    end else begin
      level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
    end
    has_room      = (level_next < LVL_W'(FIFO_DEPTH));
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = imem_addr;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = target;
        end else if (has_room) begin
          state_next = WAIT;
          addr_next  = fetch_pc;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (imem_ack && redirect_valid) begin
          fetch_pc_next = target;
          addr_next     = target;
        end else if (imem_ack) begin
          fetch_pc_next = pc_inc;
          if (has_room) begin
            addr_next = pc_inc;
          end else begin
            state_next = IDLE;
          end
        end else if (redirect_valid) begin
          // The bus forbids dropping a request, so the stale one is drained first.
          state_next    = DISCARD;
          fetch_pc_next = target;
        end else begin
          state_next = WAIT;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          fetch_pc_next = target;
        end else begin
          fetch_pc_next = fetch_pc;
        end
        if (imem_ack) begin
          state_next = WAIT;
          addr_next  = fetch_pc_next;
        end else begin
          state_next = DISCARD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    req_next = (state_next != IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC and registered imem bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      fetch_pc  <= fetch_pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  ({fetch_pc, imem_rdata}),
    .pop    (pop),
    .flush  (redirect_valid),
    .rvalid (if_valid),
    .rdata  (head),
    .level  (fifo_level)
  );

  assign if_pc    = head[63:32];
  assign if_instr = head[31:0];

endmodule
